// File: rtl/neo_pkg.sv
// Shared definitions for the NEO result reader.
//   addr_w()      : address width for an M-entry memory ($clog2(M)+1, so the
//                   value M itself fits in a count)
//   rd_state_t    : reader FSM states
//   sample_t      : signed sample at the default word width
package neo_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 16;

  function automatic int addr_w(input int m);
    return $clog2(m) + 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    PRESENT,
    DONE
  } rd_state_t;

  typedef logic signed [N_DEF-1:0] sample_t;

endpackage

// File: rtl/neo_addr_counter.sv
// Address walker for the result reader.
//   load : latch base (reduced mod M) and the word count
//   step : one word consumed; decrement remaining, advance address mod M
//   addr : current read address (drives the memory raddr directly)
//   last : remaining == 1, i.e. the current word closes the window
module neo_addr_counter import neo_pkg::*; #(
  parameter int M = 16,
  localparam int A = addr_w(M)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [A-1:0] base,
  input  logic [A-1:0] cnt,
  output logic [A-1:0] addr,
  output logic         last
);

  logic [A-1:0] rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= A'(int'(base) % M);
      rem  <= cnt;
    end else if (step) begin
      rem <= rem - 1'b1;
      // Leave the address on the final word so raddr keeps showing the
      // last location read once the window is over.
      if (rem != A'(1))
        addr <= (addr == A'(M-1)) ? '0 : addr + 1'b1;
    end
  end

  assign last = (rem == A'(1));

endmodule

// File: rtl/neo_result_reader.sv
// Read-side consumer of the NEO sample/result memory. Walks an address
// window, registers each word, flags words strictly above a signed
// threshold and presents them on a valid/ready stream.
//   start/base_addr/count/threshold : window request (sampled in IDLE)
//   raddr/rdata                     : memory port, 1-cycle registered read
//   out_data/out_spike/out_last     : word stream, qualified by out_valid
//   busy/done/spike_count           : status
// raddr is loaded one state ahead (on start / on handshake) so the memory
// sees the address throughout ISSUE and rdata is ready during CAPTURE.
module neo_result_reader import neo_pkg::*; #(
  parameter int N = 16,
  parameter int M = 16,
  localparam int A = addr_w(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [A-1:0]        base_addr,
  input  logic [A-1:0]        count,
  input  logic signed [N-1:0] threshold,
  output logic [A-1:0]        raddr,
  input  logic signed [N-1:0] rdata,
  output logic signed [N-1:0] out_data,
  output logic                out_spike,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [A-1:0]        spike_count
);

  rd_state_t           state;
  logic signed [N-1:0] thr;
  logic                ctr_load, ctr_step, ctr_last;

  assign ctr_load = (state == IDLE) && start && (count != '0);
  assign ctr_step = (state == PRESENT) && out_ready;

  neo_addr_counter #(.M(M)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .step  (ctr_step),
    .base  (base_addr),
    .cnt   (count),
    .addr  (raddr),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      thr         <= '0;
      out_data    <= '0;
      out_spike   <= 1'b0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          thr         <= threshold;
          spike_count <= '0;
          // Empty window goes straight to DONE; done is raised on entry so
          // it is high for exactly the DONE cycle.
          if (count != '0) begin
            state <= ISSUE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          out_data  <= rdata;
          out_spike <= (rdata > thr);
          out_last  <= ctr_last;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_spike && (spike_count != '1))
            spike_count <= spike_count + 1'b1;
          if (out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_result_reader.sv
module tb_neo_result_reader;
  localparam int N = 16;
  localparam int M = 16;
  localparam int A = 5;

  logic                clk = 0;
  logic                reset = 0;
  logic                start = 0;
  logic [A-1:0]        base_addr = '0;
  logic [A-1:0]        count = '0;
  logic signed [N-1:0] threshold = '0;
  logic [A-1:0]        raddr;
  logic signed [N-1:0] rdata = '0;
  logic signed [N-1:0] out_data;
  logic                out_spike, out_last, out_valid;
  logic                out_ready = 1;
  logic                busy, done;
  logic [A-1:0]        spike_count;

  neo_result_reader #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .threshold(threshold), .raddr(raddr), .rdata(rdata),
    .out_data(out_data), .out_spike(out_spike), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  // registered-read memory model
  logic signed [N-1:0] mem [M];
  always @(posedge clk) rdata <= mem[raddr[3:0]];

  typedef struct {
    logic [A-1:0]        addr;
    logic signed [N-1:0] data;
    logic                spike;
    logic                last;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_pass = 0, n_chk = 0;
  int   cyc = 0, hs_n = 0, done_n = 0, exp_spk = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  // output monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (reset && done) done_n++;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", out_data, e.data);
        chk("spike", out_spike, e.spike);
        chk("last", out_last, e.last);
        chk("raddr", raddr, e.addr);
      end
      hs_cyc.push_back(cyc);
      hs_n++;
    end
  end

  task automatic start_win(input int b, input int c, input logic signed [N-1:0] t);
    exp_spk = 0;
    for (int i = 0; i < c; i++) begin
      exp_t e;
      e.addr  = A'((b + i) % M);
      e.data  = mem[(b + i) % M];
      e.spike = (e.data > t);
      e.last  = (i == c - 1);
      if (e.spike) exp_spk++;
      sb.push_back(e);
    end
    hs_n = 0;
    hs_cyc.delete();
    @(posedge clk); #1;
    base_addr = A'(b); count = A'(c); threshold = t; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // waits for done; returns the negedge index (0 = first negedge after start)
  task automatic wait_done(input string tag, output int at);
    int d0;
    d0 = done_n;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (done_n != d0) begin at = i; break; end
    end
    if (at < 0) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_spike_count"}, spike_count, exp_spk);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      @(negedge clk);
      chk({tag, "_busy_off"}, busy, 0);
      chk({tag, "_single_done"}, done, 0);
    end
  endtask

  initial begin
    int at, d0;
    logic signed [N-1:0] hd;
    logic [A-1:0] ha;
    for (int i = 0; i < M; i++) mem[i] = N'(i * 7 - 40);

    #2;
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spikes", spike_count, 0);
    #20 reset = 1;

    // basic window, plus latency and throughput
    mem[0] = 5; mem[1] = 20; mem[2] = -3; mem[3] = 50;
    start_win(0, 4, 10);
    chk("busy_on", busy, 1);
    repeat (2) @(negedge clk);
    chk("lat_pre", out_valid, 0);
    @(negedge clk);
    chk("lat", out_valid, 1);
    wait_done("basic", at);
    chk("basic_spk2", spike_count, 2);
    if (hs_cyc.size() >= 2) chk("thru", hs_cyc[1] - hs_cyc[0], 3);
    else chk("thru_hs", hs_cyc.size(), 2);

    // wrap-around and base >= M reduction
    start_win(14, 4, 0);
    wait_done("wrap", at);
    start_win(17, 2, 0);
    wait_done("basemod", at);

    // backpressure on the second word
    start_win(0, 4, 10);
    fork
      begin
        repeat (100) begin @(negedge clk); if (hs_n >= 1) break; end
      end
    join
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("bp_valid", out_valid, 1);
    hd = out_data; ha = raddr;
    chk("bp_word", hd, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, hd);
      chk("bp_hold_spike", out_spike, 1);
      chk("bp_hold_raddr", raddr, ha);
    end
    @(posedge clk); #1;
    out_ready = 1;
    wait_done("bp", at);
    chk("bp_words", hs_n, 4);

    // zero count: done one cycle after start, no words
    start_win(3, 0, 0);
    wait_done("zero", at);
    chk("zero_at", at, 0);
    chk("zero_words", hs_n, 0);

    // start while busy is ignored
    start_win(0, 4, 10);
    repeat (4) @(posedge clk);
    #1; base_addr = 9; count = 2; threshold = 100; start = 1;
    @(posedge clk); #1; start = 0;
    wait_done("ignore", at);
    chk("ignore_words", hs_n, 4);

    // signed threshold
    mem[0] = -1; mem[1] = 0; mem[2] = -32768; mem[3] = 32767;
    start_win(0, 4, -1);
    wait_done("signed", at);

    // reset mid-window while stalled in PRESENT
    out_ready = 0;
    start_win(1, 3, -5);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("rst_mid_valid", out_valid, 1);
    d0 = done_n;
    #2 reset = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_raddr", raddr, 0);
    chk("arst_spikes", spike_count, 0);
    sb.delete();
    @(negedge clk); #2 reset = 1;
    out_ready = 1;
    chk("arst_no_done", done_n, d0);
    start_win(3, 1, -5);
    wait_done("post_rst", at);
    chk("post_rst_spk", spike_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

endmodule
